midori64_masked_ctrl: RTL and testbench
=======================================

# midori64_masked_ctrl

Sequencer for the second-order masked Midori64 core (three-share plaintext and key, `Midori64`). It accepts one block at a time over a valid/ready handshake and loads the shares into the core while the core is held in reset. It then releases the core, detects `done`, captures the output shares at a fixed offset and presents them over a valid/ready handshake. A watchdog aborts runs whose `done` never arrives. The block sits between the share-generating front end and the core. It never recombines shares.

## Interface
Parameters:
- `LOAD_CYCLES`, 2: cycles `core_reset` is held high with core inputs stable before release; legal range ≥1.
- `CAPTURE_OFFSET`, 1: cycles after the rising edge of `core_done` at which output shares are sampled; legal range 0..3.
- `MAX_CYCLES`, 64: watchdog limit on cycles spent in RUN; legal range ≥2.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1, `in_ready` out 1: block request handshake.
- `in_share1`/`in_share2`/`in_share3` in 64 each: plaintext shares.
- `key_share1`/`key_share2`/`key_share3` in 128 each: key shares, sampled together with the plaintext shares.
- `core_reset` out 1: drives the core's `reset`.
- `core_in1..3` out 64: drive the core's `input1..3`.
- `core_key1..3` out 128: drive the core's `Key1..3`.
- `core_out1..3` in 64: from the core's `output1..3`.
- `core_done` in 1: the core's `done`.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_share1..3` out 64: ciphertext shares.
- `busy` out 1: high in any state other than IDLE.
- `timeout_err` out 1: one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, LOAD, RUN, WAIT, OUT.
- **IDLE:** `in_ready`=1 and `core_reset`=1. When `in_valid&in_ready`, all six share buses are registered into the core drive registers and the FSM goes to LOAD. Pre-loading into the drive registers is what makes the first LOAD cycle already see the new shares.
- **LOAD:** `core_reset`=1, core inputs stable. A counter runs 0..LOAD_CYCLES-1. At the terminal count the FSM goes to RUN and clears the watchdog counter.
- **RUN:** `core_reset`=0.
  - `done_q` is a register of `core_done`; a rise is `core_done & ~done_q`.
  - On a rise with CAPTURE_OFFSET=0, `core_out1..3` are captured and the FSM goes to OUT.
  - On a rise with CAPTURE_OFFSET>0, the FSM goes to WAIT.
  - The watchdog increments every RUN cycle. Reaching MAX_CYCLES with no rise forces `timeout_err` for 1 cycle, a return to IDLE, and no output.
  - If a rise and the watchdog terminal count occur in the same cycle, the rise wins.
- **WAIT:** `core_reset`=0. The FSM counts CAPTURE_OFFSET cycles after the rise. In the last counted cycle `core_out1..3` are captured and the FSM goes to OUT.
- **OUT:** `core_reset`=1, `out_valid`=1, and `out_share1..3` are stable until `out_ready`.
  - On the handshake the FSM goes to IDLE.
  - On that same edge `out_share1..3` and `core_in1..3`/`core_key1..3` are cleared to 0, so no stale shares remain.
- **Share handling:** each share lives in its own register. No XOR, mux or other logic may combine bits of different share indices.
- **`in_valid` while not IDLE:** ignored, since `in_ready`=0.
- **`core_done` outside RUN:** ignored. `done_q` still tracks it, so a `done` level held across the RUN entry does not count as a rise.

## Timing
- Reset values:
  - State IDLE.
  - `core_reset`=1.
  - `in_ready`=1: it is a combinational decode of IDLE.
  - `out_valid`, `busy`, `timeout_err` = 0.
  - All share registers, counters and `done_q` = 0.
- Accept edge is T. LOAD covers cycles T+1..T+LOAD_CYCLES. `core_reset` falls at T+LOAD_CYCLES+1.
- Rise detected in cycle R gives capture at the end of cycle R+CAPTURE_OFFSET, and `out_valid` high from R+CAPTURE_OFFSET+1.
- The earliest next accept is the cycle after the `out_valid&out_ready` edge. There is no back-to-back overlap: one block is in flight.
- Asynchronous `reset` during any state immediately returns all outputs to their reset values. The core is held in reset and no partial result is emitted.

## Test plan
- **Single block, real core:** key 687ded3b3c85b3f35b1009863e2a8cbf in `key_share1`, other key shares 0; plaintext 42c20fd3b586879e in `in_share1`, other shares 0; `out_ready`=1. Required: one `out_valid` pulse with `out_share1^out_share2^out_share3` = 66bcdc6270d901cd, and `core_reset` high for exactly 2 cycles after accept.
- **Random share split:** the same plaintext and key split into three random shares each, with fresh `Static_r`/`Dynamic_r` every cycle. Required: XOR of the output shares = 66bcdc6270d901cd.
- **Back-pressure:** hold `out_ready`=0 for 20 cycles in OUT. Required: `out_share*` stable, `in_ready`=0, `core_reset`=1 throughout. After the handshake, `out_share*` = 0 and `in_ready`=1 the next cycle.
- **Watchdog:** stub core with `core_done` tied 0 and MAX_CYCLES=64. Required: exactly 64 RUN cycles, then a 1-cycle `timeout_err`, then IDLE, and `out_valid` never asserted. Also tie `core_done` to 1 before release. Required: a timeout, not a capture.
- **Two sequential blocks:** the test-vector block, then plaintext 0 with key 0. Required: the second result matches a software Midori64 model, and the first block's shares are absent from all registers between the blocks.
- **Reset mid-RUN:** assert `reset` 5 cycles after release. Required: `core_reset`=1, `busy`=0, `out_valid`=0 in the same cycle. A subsequent block completes correctly.

Source files
------------

// File: rtl/midori64_masked_ctrl_if.sv
// Bundle of every bus around the masked Midori64 sequencer: the block request
// from the share-generating front end, the drive/return buses of the core and
// the result handshake.
//   slave  : the sequencer's view (midori64_masked_ctrl)
//   master : the environment's view (front end, core, result consumer)
// Each share index has its own signal; nothing here combines shares.
interface midori64_masked_ctrl_if;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_share1;
    logic [63:0]  in_share2;
    logic [63:0]  in_share3;
    logic [127:0] key_share1;
    logic [127:0] key_share2;
    logic [127:0] key_share3;

    logic         core_reset;
    logic [63:0]  core_in1;
    logic [63:0]  core_in2;
    logic [63:0]  core_in3;
    logic [127:0] core_key1;
    logic [127:0] core_key2;
    logic [127:0] core_key3;
    logic [63:0]  core_out1;
    logic [63:0]  core_out2;
    logic [63:0]  core_out3;
    logic         core_done;

    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_share1;
    logic [63:0]  out_share2;
    logic [63:0]  out_share3;

    logic         busy;
    logic         timeout_err;

    modport slave (
        input  in_valid, in_share1, in_share2, in_share3,
               key_share1, key_share2, key_share3,
               core_out1, core_out2, core_out3, core_done, out_ready,
        output in_ready, core_reset, core_in1, core_in2, core_in3,
               core_key1, core_key2, core_key3,
               out_valid, out_share1, out_share2, out_share3,
               busy, timeout_err
    );

    modport master (
        output in_valid, in_share1, in_share2, in_share3,
               key_share1, key_share2, key_share3,
               core_out1, core_out2, core_out3, core_done, out_ready,
        input  in_ready, core_reset, core_in1, core_in2, core_in3,
               core_key1, core_key2, core_key3,
               out_valid, out_share1, out_share2, out_share3,
               busy, timeout_err
    );
endinterface

// File: rtl/midori64_masked_ctrl.sv
// Sequencer for a three-share masked Midori64 core. Accepts one block, loads
// the shares into the core while it is held in reset, releases it, waits for
// the rising edge of done, samples the output shares CAPTURE_OFFSET cycles
// later and offers them on the result handshake. A watchdog aborts a run
// whose done never rises.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active high
//   bus   : midori64_masked_ctrl_if.slave (request, core and result buses)
//
//   state  | meaning
//   IDLE   | in_ready=1, core held in reset, waiting for a block
//   LOAD   | core in reset with new shares applied, LOAD_CYCLES cycles
//   RUN    | core released, watching for done rise, watchdog counting
//   WAIT   | done seen, counting CAPTURE_OFFSET cycles to the sample point
//   OUT    | core in reset, result shares held until out_ready
module midori64_masked_ctrl #(
    parameter int LOAD_CYCLES    = 2,
    parameter int CAPTURE_OFFSET = 1,
    parameter int MAX_CYCLES     = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    midori64_masked_ctrl_if.slave bus
);
    localparam int LOAD_W = $clog2(LOAD_CYCLES + 1);
    localparam int WD_W   = $clog2(MAX_CYCLES + 1);
    localparam int OFF_W  = 2;
    localparam logic [LOAD_W-1:0] LOAD_LAST = LOAD_W'(LOAD_CYCLES - 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(MAX_CYCLES - 1);
    // Unused when CAPTURE_OFFSET is 0 because WAIT is never entered.
    localparam logic [OFF_W-1:0]  OFF_LAST  = OFF_W'(CAPTURE_OFFSET - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_OUT
    } state_t;

    state_t              state_q, state_d;
    logic [LOAD_W-1:0]   load_cnt_q, load_cnt_d;
    logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
    logic [OFF_W-1:0]    off_cnt_q, off_cnt_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;

    logic [63:0]         core_in1_q, core_in1_d;
    logic [63:0]         core_in2_q, core_in2_d;
    logic [63:0]         core_in3_q, core_in3_d;
    logic [127:0]        core_key1_q, core_key1_d;
    logic [127:0]        core_key2_q, core_key2_d;
    logic [127:0]        core_key3_q, core_key3_d;
    logic [63:0]         out_share1_q, out_share1_d;
    logic [63:0]         out_share2_q, out_share2_d;
    logic [63:0]         out_share3_q, out_share3_d;

    logic                done_rise;
    logic                capture;
    logic                clear_core;
    logic                clear_out;

    // done_q follows core_done in every state, so a level already high when
    // RUN is entered is not mistaken for a rise.
    assign done_rise = bus.core_done & ~done_q;

    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        off_cnt_d    = off_cnt_q;
        done_d       = bus.core_done;
        timeout_d    = 1'b0;
        core_in1_d   = core_in1_q;
        core_in2_d   = core_in2_q;
        core_in3_d   = core_in3_q;
        core_key1_d  = core_key1_q;
        core_key2_d  = core_key2_q;
        core_key3_d  = core_key3_q;
        out_share1_d = out_share1_q;
        out_share2_d = out_share2_q;
        out_share3_d = out_share3_q;
        capture      = 1'b0;
        clear_core   = 1'b0;
        clear_out    = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Loading the drive registers on the accept edge means the
                // first LOAD cycle already presents the new shares.
                if (bus.in_valid) begin
                    core_in1_d  = bus.in_share1;
                    core_in2_d  = bus.in_share2;
                    core_in3_d  = bus.in_share3;
                    core_key1_d = bus.key_share1;
                    core_key2_d = bus.key_share2;
                    core_key3_d = bus.key_share3;
                    load_cnt_d  = '0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_cnt_q == LOAD_LAST) begin
                    load_cnt_d = '0;
                    wd_cnt_d   = '0;
                    state_d    = S_RUN;
                end else begin
                    load_cnt_d = load_cnt_q + 1'b1;
                end
            end
            S_RUN: begin
                wd_cnt_d = wd_cnt_q + 1'b1;
                // A rise in the watchdog's last cycle still counts.
                if (done_rise) begin
                    if (CAPTURE_OFFSET == 0) begin
                        capture = 1'b1;
                        state_d = S_OUT;
                    end else begin
                        off_cnt_d = '0;
                        state_d   = S_WAIT;
                    end
                end else if (wd_cnt_q == WD_LAST) begin
                    timeout_d  = 1'b1;
                    clear_core = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            S_WAIT: begin
                if (off_cnt_q == OFF_LAST) begin
                    capture   = 1'b1;
                    off_cnt_d = '0;
                    state_d   = S_OUT;
                end else begin
                    off_cnt_d = off_cnt_q + 1'b1;
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    clear_core = 1'b1;
                    clear_out  = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            out_share1_d = bus.core_out1;
            out_share2_d = bus.core_out2;
            out_share3_d = bus.core_out3;
        end
        // Wipe shares on the way back to IDLE so nothing of a finished block
        // survives into the next one.
        if (clear_core) begin
            core_in1_d  = '0;
            core_in2_d  = '0;
            core_in3_d  = '0;
            core_key1_d = '0;
            core_key2_d = '0;
            core_key3_d = '0;
        end
        if (clear_out) begin
            out_share1_d = '0;
            out_share2_d = '0;
            out_share3_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            load_cnt_q   <= '0;
            wd_cnt_q     <= '0;
            off_cnt_q    <= '0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            core_in1_q   <= '0;
            core_in2_q   <= '0;
            core_in3_q   <= '0;
            core_key1_q  <= '0;
            core_key2_q  <= '0;
            core_key3_q  <= '0;
            out_share1_q <= '0;
            out_share2_q <= '0;
            out_share3_q <= '0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            off_cnt_q    <= off_cnt_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            core_in1_q   <= core_in1_d;
            core_in2_q   <= core_in2_d;
            core_in3_q   <= core_in3_d;
            core_key1_q  <= core_key1_d;
            core_key2_q  <= core_key2_d;
            core_key3_q  <= core_key3_d;
            out_share1_q <= out_share1_d;
            out_share2_q <= out_share2_d;
            out_share3_q <= out_share3_d;
        end
    end

    // core_reset is a state decode so an asynchronous reset forces it high
    // without waiting for a clock.
    assign bus.in_ready    = (state_q == S_IDLE);
    assign bus.core_reset  = !((state_q == S_RUN) || (state_q == S_WAIT));
    assign bus.out_valid   = (state_q == S_OUT);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.timeout_err = timeout_q;

    assign bus.core_in1    = core_in1_q;
    assign bus.core_in2    = core_in2_q;
    assign bus.core_in3    = core_in3_q;
    assign bus.core_key1   = core_key1_q;
    assign bus.core_key2   = core_key2_q;
    assign bus.core_key3   = core_key3_q;
    assign bus.out_share1  = out_share1_q;
    assign bus.out_share2  = out_share2_q;
    assign bus.out_share3  = out_share3_q;
endmodule

// File: tb/tb_midori64_masked_ctrl.sv
// Bench for midori64_masked_ctrl. The core is a behavioural stand-in: a linear
// per-share transform whose result is correct only in the cycle that lies
// CAPTURE_OFFSET cycles after done rises, so a mis-timed capture is visible.
// done rises lat_cfg cycles after release, or is tied low / high.
module tb_midori64_masked_ctrl;
    localparam int LOAD_CYCLES    = 2;
    localparam int CAPTURE_OFFSET = 1;
    localparam int MAX_CYCLES     = 64;
    localparam logic [63:0] C1 = 64'h0123456789abcdef;
    localparam logic [63:0] C2 = 64'hfedcba9876543210;
    localparam logic [63:0] C3 = 64'h0f0f0f0f0f0f0f0f;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   done_mode = 0;   // 0: rise after lat_cfg, 1: tied low, 2: tied high
    int   lat_cfg = 3;
    logic [7:0] run_cnt = '0;

    midori64_masked_ctrl_if bus_if ();

    midori64_masked_ctrl #(
        .LOAD_CYCLES   (LOAD_CYCLES),
        .CAPTURE_OFFSET(CAPTURE_OFFSET),
        .MAX_CYCLES    (MAX_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] fmod(input logic [63:0] x, input logic [127:0] k,
                                         input logic [63:0] c);
        return {x[31:0], x[63:32]} ^ k[127:64] ^ k[63:0] ^ c;
    endfunction

    always @(posedge clk) begin
        if (bus_if.core_reset) run_cnt <= '0;
        else if (run_cnt != 8'hff) run_cnt <= run_cnt + 8'd1;
    end

    logic        win;
    logic [63:0] spoil;
    assign win   = (int'(run_cnt) == lat_cfg + CAPTURE_OFFSET);
    assign spoil = win ? 64'h0 : 64'hffff_ffff_ffff_ffff;
    assign bus_if.core_done = (done_mode == 2) ? 1'b1 :
                              (done_mode == 0) ? (int'(run_cnt) >= lat_cfg) : 1'b0;
    assign bus_if.core_out1 = fmod(bus_if.core_in1, bus_if.core_key1, C1) ^ spoil;
    assign bus_if.core_out2 = fmod(bus_if.core_in2, bus_if.core_key2, C2) ^ spoil;
    assign bus_if.core_out3 = fmod(bus_if.core_in3, bus_if.core_key3, C3) ^ spoil;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] p1, input logic [63:0] p2, input logic [63:0] p3,
                        input logic [127:0] k1, input logic [127:0] k2, input logic [127:0] k3);
        check("in_ready_before_accept", bus_if.in_ready, 1);
        bus_if.in_valid   = 1'b1;
        bus_if.in_share1  = p1;
        bus_if.in_share2  = p2;
        bus_if.in_share3  = p3;
        bus_if.key_share1 = k1;
        bus_if.key_share2 = k2;
        bus_if.key_share3 = k3;
        tick();
        bus_if.in_valid = 1'b0;
        check("busy_in_load", bus_if.busy, 1);
        check("in_ready_in_load", bus_if.in_ready, 0);
        check("core_in1_loaded", bus_if.core_in1, p1);
        check("core_in3_loaded", bus_if.core_in3, p3);
        check("core_key2_loaded", bus_if.core_key2, k2);
    endtask

    // Returns at the negedge of the cycle in which core_reset first falls.
    task automatic wait_release;
        int n = 0;
        while (bus_if.core_reset && n < 10) begin
            n++;
            tick();
        end
        check("core_reset_hold_cycles", n, LOAD_CYCLES);
    endtask

    // Sends one block, checks result timing and shares; returns in the first
    // OUT cycle.
    task automatic do_block(input logic [63:0] p1, input logic [63:0] p2, input logic [63:0] p3,
                            input logic [127:0] k1, input logic [127:0] k2, input logic [127:0] k3);
        int lat = 0;
        send(p1, p2, p3, k1, k2, k3);
        wait_release();
        while (!bus_if.out_valid && lat < 100) begin
            lat++;
            tick();
        end
        check("out_valid_latency", lat, lat_cfg + CAPTURE_OFFSET + 1);
        check("core_reset_in_out", bus_if.core_reset, 1);
        check("out_share1", bus_if.out_share1, fmod(p1, k1, C1));
        check("out_share2", bus_if.out_share2, fmod(p2, k2, C2));
        check("out_share3", bus_if.out_share3, fmod(p3, k3, C3));
        check("out_recombined", bus_if.out_share1 ^ bus_if.out_share2 ^ bus_if.out_share3,
              fmod(p1 ^ p2 ^ p3, k1 ^ k2 ^ k3, C1 ^ C2 ^ C3));
    endtask

    // Call in OUT with out_ready=1; checks the cycle after the handshake.
    task automatic after_handshake;
        tick();
        check("out_valid_after_hs", bus_if.out_valid, 0);
        check("in_ready_after_hs", bus_if.in_ready, 1);
        check("out_share1_cleared", bus_if.out_share1, 0);
        check("out_share2_cleared", bus_if.out_share2, 0);
        check("out_share3_cleared", bus_if.out_share3, 0);
        check("core_in_cleared", {bus_if.core_in1, bus_if.core_in2, bus_if.core_in3}, 0);
        check("core_key1_cleared", bus_if.core_key1, 0);
        check("core_key2_cleared", bus_if.core_key2, 0);
        check("core_key3_cleared", bus_if.core_key3, 0);
    endtask

    task automatic do_timeout(input int mode, input string tag);
        int  n = 0;
        logic saw_ov = 1'b0;
        done_mode = mode;
        tick();
        send(64'h1111, 64'h2222, 64'h3333, 128'h4, 128'h5, 128'h6);
        wait_release();
        while (!bus_if.core_reset && n < 200) begin
            n++;
            if (bus_if.out_valid) saw_ov = 1'b1;
            tick();
        end
        check({tag, "_run_cycles"}, n, MAX_CYCLES);
        check({tag, "_timeout_pulse"}, bus_if.timeout_err, 1);
        check({tag, "_busy_after"}, bus_if.busy, 0);
        check({tag, "_out_valid_never"}, saw_ov | bus_if.out_valid, 0);
        tick();
        check({tag, "_timeout_one_cycle"}, bus_if.timeout_err, 0);
        done_mode = 0;
    endtask

    localparam logic [63:0]  PT  = 64'h42c20fd3b586879e;
    localparam logic [127:0] KEY = 128'h687ded3b3c85b3f35b1009863e2a8cbf;

    initial begin
        logic [63:0]  r1, r2, s1, s2;
        logic [127:0] q1, q2;
        logic [63:0]  held1, held2, held3;

        bus_if.in_valid   = 1'b0;
        bus_if.in_share1  = '0;
        bus_if.in_share2  = '0;
        bus_if.in_share3  = '0;
        bus_if.key_share1 = '0;
        bus_if.key_share2 = '0;
        bus_if.key_share3 = '0;
        bus_if.out_ready  = 1'b1;

        // Reset state
        tick(); tick();
        check("rst_in_ready", bus_if.in_ready, 1);
        check("rst_core_reset", bus_if.core_reset, 1);
        check("rst_out_valid", bus_if.out_valid, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_timeout", bus_if.timeout_err, 0);
        check("rst_out_share1", bus_if.out_share1, 0);
        check("rst_core_in1", bus_if.core_in1, 0);
        reset = 1'b0;
        tick();

        // Test vector block, plain in share 1, followed by an all-zero block
        do_block(PT, 64'h0, 64'h0, KEY, 128'h0, 128'h0);
        after_handshake();
        do_block(64'h0, 64'h0, 64'h0, 128'h0, 128'h0, 128'h0);
        after_handshake();

        // Random three-way split of the same block
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        q1 = {$urandom(), $urandom(), $urandom(), $urandom()};
        q2 = {$urandom(), $urandom(), $urandom(), $urandom()};
        do_block(r1, r2, PT ^ r1 ^ r2, q1, q2, KEY ^ q1 ^ q2);
        after_handshake();

        // Back-pressure with an ignored request during OUT
        bus_if.out_ready = 1'b0;
        s1 = 64'h0badcafe12345678;
        s2 = 64'h7766554433221100;
        do_block(s1, s2, 64'h5, 128'h9, KEY, 128'h1);
        held1 = bus_if.out_share1;
        held2 = bus_if.out_share2;
        held3 = bus_if.out_share3;
        bus_if.in_valid  = 1'b1;
        bus_if.in_share1 = 64'hdeaddeaddeaddead;
        for (int i = 0; i < 19; i++) begin
            tick();
            check("bp_out_share1_stable", bus_if.out_share1, held1);
            check("bp_out_share23_stable", {bus_if.out_share2, bus_if.out_share3},
                  {held2, held3});
            check("bp_in_ready_low", bus_if.in_ready, 0);
            check("bp_core_reset_high", bus_if.core_reset, 1);
        end
        check("bp_core_in1_unchanged", bus_if.core_in1, s1);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        after_handshake();

        // Watchdog: done never comes, then done already high before release
        do_timeout(1, "wd_low");
        do_timeout(2, "wd_high");

        // Asynchronous reset in the middle of RUN
        lat_cfg = 20;
        send(64'hfeed, 64'hbeef, 64'hf00d, 128'h7, 128'h8, 128'h9);
        wait_release();
        for (int i = 0; i < 5; i++) tick();
        check("mid_run_busy", bus_if.busy, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_core_reset", bus_if.core_reset, 1);
        check("async_rst_busy", bus_if.busy, 0);
        check("async_rst_out_valid", bus_if.out_valid, 0);
        check("async_rst_core_in1", bus_if.core_in1, 0);
        tick();
        reset = 1'b0;
        lat_cfg = 3;
        tick();
        do_block(64'h0123, 64'h4567, 64'h89ab, KEY, 128'h55, 128'haa);
        after_handshake();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
